// File: rtl/scg_cmd_exec_if.sv
// Bus bundle between the opcode sequencer and the SDRAM command executor.
// SCG_EXEC_ILLEGAL_FLAG_EN adds the err flag to the bundle.
interface scg_cmd_exec_if;
    logic [3:0]  select;
    logic [1:0]  bank;
    logic [11:0] row;
    logic [8:0]  col;
    logic [11:0] mode_word;
    logic        done;
    logic        sd_cs_n;
    logic        sd_ras_n;
    logic        sd_cas_n;
    logic        sd_we_n;
    logic        sd_cke;
    logic [1:0]  sd_ba;
    logic [11:0] sd_addr;
    logic        sd_dqm;
    logic        rd_valid;
    logic        wr_req;
`ifdef SCG_EXEC_ILLEGAL_FLAG_EN
    logic        err;

    modport master (
        output select, bank, row, col, mode_word,
        input  done, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_cke,
               sd_ba, sd_addr, sd_dqm, rd_valid, wr_req, err
    );
    modport slave (
        input  select, bank, row, col, mode_word,
        output done, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_cke,
               sd_ba, sd_addr, sd_dqm, rd_valid, wr_req, err
    );
`else
    modport master (
        output select, bank, row, col, mode_word,
        input  done, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_cke,
               sd_ba, sd_addr, sd_dqm, rd_valid, wr_req
    );
    modport slave (
        input  select, bank, row, col, mode_word,
        output done, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_cke,
               sd_ba, sd_addr, sd_dqm, rd_valid, wr_req
    );
`endif
endinterface

// File: rtl/scg_cmd_exec.sv
// SDRAM command executor: drives command pins, times each command, pulses done.
// Define SCG_EXEC_ILLEGAL_FLAG_EN to flag (and drop) illegal codes on err.
module scg_cmd_exec #(
    parameter int unsigned T_RCD     = 2,
    parameter int unsigned T_RP      = 2,
    parameter int unsigned T_RFC     = 7,
    parameter int unsigned T_MRD     = 2,
    parameter int unsigned T_XSR     = 8,
    parameter int unsigned CAS_LAT   = 2,
    parameter int unsigned BURST_LEN = 4
) (
    input logic           clk,
    input logic           n_rst,
    scg_cmd_exec_if.slave io_cmd
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned W_MAX = max2(max2(max2(T_RCD, CAS_LAT + BURST_LEN), max2(T_RFC, T_XSR)),
                                         max2(max2(T_RP, T_MRD), max2(CAS_LAT + 1, BURST_LEN)));
    localparam int unsigned CNT_W = ($clog2(W_MAX) > 4) ? $clog2(W_MAX) : 4;

    localparam logic [3:0] SEL_NOP  = 4'd0;
    localparam logic [3:0] SEL_ACT  = 4'd1;
    localparam logic [3:0] SEL_RD1  = 4'd2;
    localparam logic [3:0] SEL_RDB  = 4'd3;
    localparam logic [3:0] SEL_WR1  = 4'd4;
    localparam logic [3:0] SEL_WRB  = 4'd5;
    localparam logic [3:0] SEL_REF  = 4'd6;
    localparam logic [3:0] SEL_SRE  = 4'd7;
    localparam logic [3:0] SEL_SRX  = 4'd8;
    localparam logic [3:0] SEL_PREA = 4'd9;
    localparam logic [3:0] SEL_PREB = 4'd10;
    localparam logic [3:0] SEL_LMR  = 4'd11;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_RD    = 4'b0101;
    localparam logic [3:0] CMD_WR    = 4'b0100;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_DONE} state_t;

    // Counter load value is W-1 so the largest W never needs an extra bit.
    function automatic logic [CNT_W-1:0] load_of(input logic [3:0] sel);
        int unsigned w;
        case (sel)
            SEL_ACT:            w = T_RCD;
            SEL_RD1:            w = CAS_LAT + 1;
            SEL_RDB:            w = CAS_LAT + BURST_LEN;
            SEL_WRB:            w = BURST_LEN;
            SEL_REF:            w = T_RFC;
            SEL_SRX:            w = T_XSR;
            SEL_PREA, SEL_PREB: w = T_RP;
            SEL_LMR:            w = T_MRD;
            default:            w = 1;
        endcase
        return CNT_W'(w - 1);
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_sel;
    logic             r_done;
    logic [3:0]       r_cmd;
    logic             r_cke;
    logic [1:0]       r_ba;
    logic [11:0]      r_addr;
    logic             r_dqm;
    logic             r_rd_valid;
    logic             r_wr_req;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_sel_nxt;
    logic [3:0]       w_cmd_nxt;
    logic             w_cke_nxt;
    logic [1:0]       w_ba_nxt;
    logic [11:0]      w_addr_nxt;
    logic             w_rd_nxt;
    logic             w_wr_nxt;
    logic             w_illegal;
    logic [CNT_W-1:0] w_beats;
`ifdef SCG_EXEC_ILLEGAL_FLAG_EN
    logic             r_err;
    logic             w_err_nxt;
`endif

    // Next state, counter and registered pin values
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_cmd_nxt   = CMD_NOP;
        w_cke_nxt   = r_cke;
        w_ba_nxt    = r_ba;
        w_addr_nxt  = r_addr;
        w_illegal   = 1'b0;
        w_beats     = CNT_W'(1);
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
`ifdef SCG_EXEC_ILLEGAL_FLAG_EN
        w_err_nxt   = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
`ifdef SCG_EXEC_ILLEGAL_FLAG_EN
                w_illegal = (io_cmd.select > SEL_LMR) ||
                            (!r_cke && (io_cmd.select != SEL_NOP) && (io_cmd.select != SEL_SRX));
                w_err_nxt = w_illegal;
`else
                w_illegal = (io_cmd.select > SEL_LMR);
`endif
                if ((io_cmd.select != SEL_NOP) && !w_illegal) begin
                    w_state_nxt = S_CMD;
                    w_sel_nxt   = io_cmd.select;
                    case (io_cmd.select)
                        SEL_ACT: begin
                            w_cmd_nxt  = CMD_ACT;
                            w_ba_nxt   = io_cmd.bank;
                            w_addr_nxt = io_cmd.row;
                        end
                        SEL_RD1, SEL_RDB: begin
                            w_cmd_nxt  = CMD_RD;
                            w_ba_nxt   = io_cmd.bank;
                            w_addr_nxt = {3'b000, io_cmd.col};
                        end
                        SEL_WR1, SEL_WRB: begin
                            w_cmd_nxt  = CMD_WR;
                            w_ba_nxt   = io_cmd.bank;
                            w_addr_nxt = {3'b000, io_cmd.col};
                        end
                        SEL_REF: w_cmd_nxt = CMD_REF;
                        SEL_SRE: begin
                            w_cmd_nxt = CMD_REF;
                            w_cke_nxt = 1'b0;
                        end
                        SEL_SRX: w_cke_nxt = 1'b1;
                        SEL_PREA: begin
                            w_cmd_nxt  = CMD_PRE;
                            w_ba_nxt   = io_cmd.bank;
                            w_addr_nxt = 12'h400;
                        end
                        SEL_PREB: begin
                            w_cmd_nxt  = CMD_PRE;
                            w_ba_nxt   = io_cmd.bank;
                            w_addr_nxt = 12'h000;
                        end
                        SEL_LMR: begin
                            w_cmd_nxt  = CMD_LMR;
                            w_ba_nxt   = 2'b00;
                            w_addr_nxt = io_cmd.mode_word;
                        end
                        default: w_cmd_nxt = CMD_NOP;
                    endcase
                end
            end
            S_CMD: begin
                w_cnt_nxt   = load_of(r_sel);
                w_state_nxt = (load_of(r_sel) == CNT_W'(0)) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Read beats occupy the last counter values before done
        if (w_sel_nxt == SEL_RDB) begin
            w_beats = CNT_W'(BURST_LEN);
        end
        w_rd_nxt = (w_state_nxt == S_WAIT) && ((w_sel_nxt == SEL_RD1) || (w_sel_nxt == SEL_RDB)) &&
                   (w_cnt_nxt <= w_beats);
        w_wr_nxt = ((w_state_nxt == S_CMD) || (w_state_nxt == S_WAIT)) &&
                   ((w_sel_nxt == SEL_WR1) || (w_sel_nxt == SEL_WRB));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sel      <= SEL_NOP;
            r_done     <= 1'b0;
            r_cmd      <= CMD_DESEL;
            r_cke      <= 1'b1;
            r_ba       <= 2'b00;
            r_addr     <= 12'h000;
            r_dqm      <= 1'b1;
            r_rd_valid <= 1'b0;
            r_wr_req   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_done     <= (w_state_nxt == S_DONE);
            r_cmd      <= w_cmd_nxt;
            r_cke      <= w_cke_nxt;
            r_ba       <= w_ba_nxt;
            r_addr     <= w_addr_nxt;
            r_dqm      <= !(w_rd_nxt || w_wr_nxt);
            r_rd_valid <= w_rd_nxt;
            r_wr_req   <= w_wr_nxt;
        end
    end

`ifdef SCG_EXEC_ILLEGAL_FLAG_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign io_cmd.err = r_err;
`endif

    assign io_cmd.done     = r_done;
    assign io_cmd.sd_cs_n  = r_cmd[3];
    assign io_cmd.sd_ras_n = r_cmd[2];
    assign io_cmd.sd_cas_n = r_cmd[1];
    assign io_cmd.sd_we_n  = r_cmd[0];
    assign io_cmd.sd_cke   = r_cke;
    assign io_cmd.sd_ba    = r_ba;
    assign io_cmd.sd_addr  = r_addr;
    assign io_cmd.sd_dqm   = r_dqm;
    assign io_cmd.rd_valid = r_rd_valid;
    assign io_cmd.wr_req   = r_wr_req;

endmodule

// File: tb/tb_scg_cmd_exec.sv
// Scoreboard bench for scg_cmd_exec: expected commands queued, checked on each done.
// Build with SCG_EXEC_ILLEGAL_FLAG_EN to also exercise the err flag.
module tb_scg_cmd_exec;

    localparam int unsigned HD = 32;

    typedef struct {
        string       name;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [11:0] addr;
        logic        chk_ba;
        logic        cke;
        int unsigned w;
        int unsigned rd_start;
        int unsigned rd_beats;
        int unsigned wr_beats;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;

    scg_cmd_exec_if bus();

    scg_cmd_exec dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .io_cmd (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cyc     = 0;
    int unsigned n_cmds  = 0;
    int unsigned n_done  = 0;
    exp_t        sb_q[$];

    logic [3:0]  h_cmd  [HD];
    logic [1:0]  h_ba   [HD];
    logic [11:0] h_addr [HD];
    logic        h_cke  [HD];
    logic        h_rd   [HD];
    logic        h_wr   [HD];
    logic        h_dqm  [HD];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic push(input string name, input logic [3:0] cmd, input logic [1:0] ba,
                        input logic [11:0] addr, input logic chk_ba, input logic cke,
                        input int unsigned w, input int unsigned rd_start,
                        input int unsigned rd_beats, input int unsigned wr_beats);
        exp_t e;
        e.name = name; e.cmd = cmd; e.ba = ba; e.addr = addr; e.chk_ba = chk_ba; e.cke = cke;
        e.w = w; e.rd_start = rd_start; e.rd_beats = rd_beats; e.wr_beats = wr_beats;
        sb_q.push_back(e);
    endtask

    // Done seen at cycle cyc: command cycle must be exactly w cycles back
    task automatic verify(input exp_t e);
        int unsigned c = cyc - e.w;
        logic        all_nop = 1'b1;
        logic [15:0] g_rd = '0, x_rd = '0, g_wr = '0, x_wr = '0, g_dq = '0, x_dq = '0;
        check({e.name, "_cmd"}, 32'(h_cmd[c % HD]), 32'(e.cmd));
        check({e.name, "_cke"}, 32'(h_cke[c % HD]), 32'(e.cke));
        if (e.chk_ba) check({e.name, "_ba_addr"}, 32'({h_ba[c % HD], h_addr[c % HD]}), 32'({e.ba, e.addr}));
        for (int unsigned k = 1; k <= e.w; k++)
            if (h_cmd[(c + k) % HD] !== 4'b0111) all_nop = 1'b0;
        check({e.name, "_nop_after_cmd"}, 32'(all_nop), 32'd1);
        for (int unsigned k = 0; k <= e.w; k++) begin
            x_rd[k] = (k >= e.rd_start) && (k < e.rd_start + e.rd_beats);
            x_wr[k] = (k < e.wr_beats);
            x_dq[k] = !(x_rd[k] || x_wr[k]);
            g_rd[k] = h_rd[(c + k) % HD];
            g_wr[k] = h_wr[(c + k) % HD];
            g_dq[k] = h_dqm[(c + k) % HD];
        end
        check({e.name, "_rd_valid"}, 32'(g_rd), 32'(x_rd));
        check({e.name, "_wr_req"},   32'(g_wr), 32'(x_wr));
        check({e.name, "_dqm"},      32'(g_dq), 32'(x_dq));
    endtask

    task automatic monitor();
        logic done_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            h_cmd[cyc % HD]  = {bus.sd_cs_n, bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n};
            h_ba[cyc % HD]   = bus.sd_ba;
            h_addr[cyc % HD] = bus.sd_addr;
            h_cke[cyc % HD]  = bus.sd_cke;
            h_rd[cyc % HD]   = bus.rd_valid;
            h_wr[cyc % HD]   = bus.wr_req;
            h_dqm[cyc % HD]  = bus.sd_dqm;
            if (!bus.sd_cs_n && ({bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n} != 3'b111)) n_cmds++;
            if (done_prev) check("done_one_cycle", 32'(bus.done), 32'd0);
            done_prev = bus.done;
            if (bus.done === 1'b1) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    verify(sb_q.pop_front());
                end
            end
        end
    endtask

    task automatic issue(input logic [3:0] sel, input logic [1:0] bank, input logic [11:0] row,
                         input logic [8:0] col, input logic [11:0] mode);
        @(negedge clk);
        bus.select = sel; bus.bank = bank; bus.row = row; bus.col = col; bus.mode_word = mode;
        @(posedge clk);
        @(posedge clk);
        #1 bus.select = 4'd0;
    endtask

    task automatic wait_done(input string name, output time t);
        int unsigned n   = 0;
        logic        got = 1'b0;
        t = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                t   = $time;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL %s_timeout: got no done in %0d cycles expected done", name, n);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_pins"}, 32'({bus.sd_cs_n, bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n, bus.sd_cke,
                                    bus.sd_dqm, bus.rd_valid, bus.wr_req, bus.done}), 32'h1F8);
        check({name, "_ba_addr"}, 32'({bus.sd_ba, bus.sd_addr}), 32'd0);
`ifdef SCG_EXEC_ILLEGAL_FLAG_EN
        check({name, "_err"}, 32'(bus.err), 32'd0);
`endif
    endtask

    initial begin
        time         t1, t2, tx;
        int unsigned cmds0, done0, errs;
        bus.select = 4'd0; bus.bank = 2'd0; bus.row = 12'd0; bus.col = 9'd0; bus.mode_word = 12'd0;
        n_rst = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_reset("reset");
        n_rst = 1'b1;

        push("lmr", 4'b0000, 2'd0, 12'h022, 1'b1, 1'b1, 2, 0, 0, 0);
        issue(4'd11, 2'd3, 12'h0, 9'h0, 12'h022);
        wait_done("lmr", tx);

        push("act", 4'b0011, 2'd2, 12'h1A5, 1'b1, 1'b1, 2, 0, 0, 0);
        issue(4'd1, 2'd2, 12'h1A5, 9'h0, 12'h0);
        wait_done("act", tx);

        push("rd_burst", 4'b0101, 2'd2, 12'h0F3, 1'b1, 1'b1, 6, 2, 4, 0);
        issue(4'd3, 2'd2, 12'hFFF, 9'h0F3, 12'h0);
        wait_done("rd_burst", tx);

        push("rd_single", 4'b0101, 2'd1, 12'h1FF, 1'b1, 1'b1, 3, 2, 1, 0);
        issue(4'd2, 2'd1, 12'h0, 9'h1FF, 12'h0);
        wait_done("rd_single", tx);

        push("wr_single", 4'b0100, 2'd3, 12'h0AA, 1'b1, 1'b1, 1, 0, 0, 1);
        issue(4'd4, 2'd3, 12'h0, 9'h0AA, 12'h0);
        wait_done("wr_single", tx);

        push("wr_burst", 4'b0100, 2'd0, 12'h155, 1'b1, 1'b1, 4, 0, 0, 4);
        issue(4'd5, 2'd0, 12'h0, 9'h155, 12'h0);
        wait_done("wr_burst", tx);

        push("pre_all", 4'b0010, 2'd1, 12'h400, 1'b1, 1'b1, 2, 0, 0, 0);
        issue(4'd9, 2'd1, 12'h0, 9'h0, 12'h0);
        wait_done("pre_all", tx);

        push("pre_bank", 4'b0010, 2'd3, 12'h000, 1'b1, 1'b1, 2, 0, 0, 0);
        issue(4'd10, 2'd3, 12'h7FF, 9'h0, 12'h0);
        wait_done("pre_bank", tx);

        // Held refresh code runs twice, command cycles W+2 apart
        push("ref1", 4'b0001, 2'd0, 12'h0, 1'b0, 1'b1, 7, 0, 0, 0);
        push("ref2", 4'b0001, 2'd0, 12'h0, 1'b0, 1'b1, 7, 0, 0, 0);
        @(negedge clk);
        bus.select = 4'd6;
        wait_done("ref1", t1);
        wait_done("ref2", t2);
        bus.select = 4'd0;
        check("ref_spacing_cycles", 32'((t2 - t1) / 10), 32'd9);

        push("sr_entry", 4'b0001, 2'd0, 12'h0, 1'b0, 1'b0, 1, 0, 0, 0);
        issue(4'd7, 2'd0, 12'h0, 9'h0, 12'h0);
        wait_done("sr_entry", tx);
        repeat (3) @(negedge clk);
        check("cke_held_in_sr", 32'(bus.sd_cke), 32'd0);
        push("sr_exit", 4'b0111, 2'd0, 12'h0, 1'b0, 1'b1, 8, 0, 0, 0);
        issue(4'd8, 2'd0, 12'h0, 9'h0, 12'h0);
        wait_done("sr_exit", tx);
        @(negedge clk);
        check("cke_after_sr_exit", 32'(bus.sd_cke), 32'd1);

        // Code 13: never a command or done; err pulse when the flag exists
        @(negedge clk);
        cmds0 = n_cmds; done0 = n_done; errs = 0;
        bus.select = 4'd13;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) bus.select = 4'd0;
`ifdef SCG_EXEC_ILLEGAL_FLAG_EN
            if (bus.err === 1'b1) errs++;
`endif
        end
`ifdef SCG_EXEC_ILLEGAL_FLAG_EN
        check("illegal_err_cycles", 32'(errs), 32'd1);
`endif
        check("illegal_no_cmd", 32'(n_cmds - cmds0), 32'd0);
        check("illegal_no_done", 32'(n_done - done0), 32'd0);
        check("illegal_pins_nop", 32'({bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n}), 32'h7);

        // Asynchronous reset in the middle of a write burst
        issue(4'd5, 2'd2, 12'h0, 9'h033, 12'h0);
        #1 n_rst = 1'b0;
        #1 check_reset("midop_reset");
        @(negedge clk);
        n_rst = 1'b1;
        cmds0 = n_cmds; done0 = n_done;
        repeat (10) @(negedge clk);
        check("after_reset_no_cmd", 32'(n_cmds - cmds0), 32'd0);
        check("after_reset_no_done", 32'(n_done - done0), 32'd0);

        push("act_recover", 4'b0011, 2'd1, 12'hABC, 1'b1, 1'b1, 2, 0, 0, 0);
        issue(4'd1, 2'd1, 12'hABC, 9'h0, 12'h0);
        wait_done("act_recover", tx);
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
